// File: rtl/forward_scoreboard.sv
// Operand bypass network with a per-register busy scoreboard for long-latency writers and stall generation.
// Optional build macro FWD_PERF_CNT_EN adds saturating stallCycles / forwardHits counters.
module forward_scoreboard #(
    parameter int XLEN       = 32,
    parameter int NUM_READ   = 2,
    parameter int NUM_STAGES = 2,
    parameter int NUM_REGS   = 32,
    localparam int RW        = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic [NUM_READ-1:0]          readValid,
    input  logic [NUM_READ*RW-1:0]       readReg,
    input  logic [NUM_STAGES-1:0]        stageValid,
    input  logic [NUM_STAGES-1:0]        stageWriteEnable,
    input  logic [NUM_STAGES*RW-1:0]     stageDestReg,
    input  logic [NUM_STAGES-1:0]        stageDataReady,
    input  logic [NUM_STAGES*XLEN-1:0]   stageData,
    input  logic                         issueValid,
    input  logic                         issueLongLat,
    input  logic [RW-1:0]                issueDestReg,
    input  logic                         retireValid,
    input  logic [RW-1:0]                retireDestReg,
    input  logic                         flush,
    output logic [NUM_READ-1:0]          forwardEnable,
    output logic [NUM_READ*XLEN-1:0]     forwardData,
    output logic                         stall,
    output logic [NUM_REGS-1:0]          busyVector
`ifdef FWD_PERF_CNT_EN
    ,
    output logic [31:0]                  stallCycles,
    output logic [31:0]                  forwardHits
`endif
);

    logic [NUM_REGS-1:0] busyReg;
    logic [NUM_REGS-1:0] busyNext;
    logic [NUM_READ-1:0] portStall;
    logic                wawStall;
    logic                issueLongValid;

    assign busyVector = busyReg;

    // Per source port: youngest matching stage is authoritative, scoreboard covers everything else.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_READ; gi++) begin : gPort
            logic [RW-1:0]   portReg;
            logic            portActive;
            logic            stageHit;
            logic            stageReady;
            logic [XLEN-1:0] stageValue;

            assign portReg    = readReg[gi*RW +: RW];
            assign portActive = readValid[gi] && (portReg != '0);

            always_comb begin
                stageHit   = 1'b0;
                stageReady = 1'b0;
                stageValue = '0;
                for (int s = 0; s < NUM_STAGES; s++) begin
                    if (!stageHit && stageValid[s] && stageWriteEnable[s] &&
                        (stageDestReg[s*RW +: RW] == portReg) &&
                        (stageDestReg[s*RW +: RW] != '0)) begin
                        stageHit   = 1'b1;
                        stageReady = stageDataReady[s];
                        stageValue = stageData[s*XLEN +: XLEN];
                    end
                end
            end

            always_comb begin
                forwardEnable[gi]             = portActive && stageHit && stageReady;
                forwardData[gi*XLEN +: XLEN]  = forwardEnable[gi] ? stageValue : '0;
                if (!portActive)
                    portStall[gi] = 1'b0;
                else if (stageHit)
                    portStall[gi] = !stageReady;
                else
                    portStall[gi] = busyReg[portReg];
            end
        end
    endgenerate

    // Only one outstanding long-latency writer per register is allowed.
    assign issueLongValid = issueValid && issueLongLat && (issueDestReg != '0);
    assign wawStall       = issueLongValid && busyReg[issueDestReg];
    assign stall          = ((|portStall) || wawStall) && !flush;

    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : gBusy
            if (gi == 0) begin : gZero
                assign busyNext[gi] = 1'b0;
            end else begin : gReg
                logic setBit;
                logic clearBit;
                assign setBit   = issueLongValid && !stall && !flush && (issueDestReg == RW'(gi));
                assign clearBit = retireValid && (retireDestReg == RW'(gi));
                // A same-cycle set belongs to a younger writer, so it overrides the retire.
                assign busyNext[gi] = setBit || (busyReg[gi] && !clearBit);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN)
            busyReg <= '0;
        else
            busyReg <= busyNext;
    end

`ifdef FWD_PERF_CNT_EN
    logic [31:0] stallCyclesReg;
    logic [31:0] forwardHitsReg;
    logic [31:0] hitCount;
    logic [32:0] stallSum;
    logic [32:0] hitSum;

    always_comb begin
        hitCount = '0;
        for (int p = 0; p < NUM_READ; p++)
            hitCount = hitCount + 32'(forwardEnable[p]);
    end

    assign stallSum = {1'b0, stallCyclesReg} + 33'd1;
    assign hitSum   = {1'b0, forwardHitsReg} + {1'b0, hitCount};

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            stallCyclesReg <= '0;
            forwardHitsReg <= '0;
        end else begin
            if (stall)
                stallCyclesReg <= stallSum[32] ? '1 : stallSum[31:0];
            else
                forwardHitsReg <= hitSum[32] ? '1 : hitSum[31:0];
        end
    end

    assign stallCycles = stallCyclesReg;
    assign forwardHits = forwardHitsReg;
`endif

endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: bypass priority, scoreboard RAW/WAW stalls, x0 handling, async reset.
`timescale 1ns/1ps
module tb_forward_scoreboard;

    localparam int XLEN = 32;
    localparam int NR   = 2;
    localparam int NS   = 2;
    localparam int NREG = 32;
    localparam int RW   = 5;

    logic                 clk = 1'b0;
    logic                 rstN;
    logic [NR-1:0]        readValid;
    logic [NR*RW-1:0]     readReg;
    logic [NS-1:0]        stageValid;
    logic [NS-1:0]        stageWriteEnable;
    logic [NS*RW-1:0]     stageDestReg;
    logic [NS-1:0]        stageDataReady;
    logic [NS*XLEN-1:0]   stageData;
    logic                 issueValid;
    logic                 issueLongLat;
    logic [RW-1:0]        issueDestReg;
    logic                 retireValid;
    logic [RW-1:0]        retireDestReg;
    logic                 flush;
    logic [NR-1:0]        forwardEnable;
    logic [NR*XLEN-1:0]   forwardData;
    logic                 stall;
    logic [NREG-1:0]      busyVector;
`ifdef FWD_PERF_CNT_EN
    logic [31:0]          stallCycles;
    logic [31:0]          forwardHits;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    forward_scoreboard #(.XLEN(XLEN), .NUM_READ(NR), .NUM_STAGES(NS), .NUM_REGS(NREG)) dut (
        .clk(clk), .rstN(rstN),
        .readValid(readValid), .readReg(readReg),
        .stageValid(stageValid), .stageWriteEnable(stageWriteEnable),
        .stageDestReg(stageDestReg), .stageDataReady(stageDataReady), .stageData(stageData),
        .issueValid(issueValid), .issueLongLat(issueLongLat), .issueDestReg(issueDestReg),
        .retireValid(retireValid), .retireDestReg(retireDestReg), .flush(flush),
        .forwardEnable(forwardEnable), .forwardData(forwardData),
        .stall(stall), .busyVector(busyVector)
`ifdef FWD_PERF_CNT_EN
        , .stallCycles(stallCycles), .forwardHits(forwardHits)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        readValid = '0; readReg = '0;
        stageValid = '0; stageWriteEnable = '0; stageDestReg = '0;
        stageDataReady = '0; stageData = '0;
        issueValid = 1'b0; issueLongLat = 1'b0; issueDestReg = '0;
        retireValid = 1'b0; retireDestReg = '0; flush = 1'b0;
    endtask

    initial begin
        idle();
        rstN = 1'b0;
        #1;
        $display("step reset: busy=%h stall=%b fe=%b", busyVector, stall, forwardEnable);
        check("reset_busy", busyVector, 32'h0);
        check("reset_stall", stall, 1'b0);
        check("reset_fe", forwardEnable, 2'b00);
        check("reset_fd", forwardData, 64'h0);
        @(negedge clk); rstN = 1'b1;

        // Youngest stage wins when both hold x5
        @(negedge clk);
        stageValid = 2'b11; stageWriteEnable = 2'b11; stageDestReg = {5'd5, 5'd5};
        stageDataReady = 2'b11; stageData = {32'h22, 32'h11};
        readValid = 2'b11; readReg = {5'd5, 5'd5};
        #1;
        $display("step fwd_x5: fe=%b fd=%h stall=%b", forwardEnable, forwardData, stall);
        check("x5_fe", forwardEnable, 2'b11);
        check("x5_fd", forwardData, {32'h11, 32'h11});
        check("x5_stall", stall, 1'b0);

        // Not-ready youngest match stalls, older ready match ignored
        @(negedge clk);
        stageDestReg = {5'd7, 5'd7}; stageDataReady = 2'b10; stageData = {32'h33, 32'h0};
        readValid = 2'b01; readReg = {5'd0, 5'd7};
        #1;
        $display("step x7_notready: fe=%b stall=%b", forwardEnable, stall);
        check("x7_stall", stall, 1'b1);
        check("x7_fe", forwardEnable, 2'b00);
        @(negedge clk);
        stageDataReady = 2'b11; stageData = {32'h33, 32'h44};
        #1;
        $display("step x7_ready: fe=%b fd=%h stall=%b", forwardEnable, forwardData, stall);
        check("x7r_fd", forwardData, {32'h0, 32'h44});
        check("x7r_fe", forwardEnable, 2'b01);
        check("x7r_stall", stall, 1'b0);

        // Long-latency load to x9, RAW stall until retire
        @(negedge clk);
        idle();
        issueValid = 1'b1; issueLongLat = 1'b1; issueDestReg = 5'd9;
        #1;
        $display("step issue_x9: stall=%b", stall);
        check("x9_issue_stall", stall, 1'b0);
        @(negedge clk);
        idle();
        readValid = 2'b01; readReg = {5'd0, 5'd9};
        #1;
        $display("step read_x9: busy=%h stall=%b", busyVector, stall);
        check("x9_busy", busyVector, 32'h0000_0200);
        check("x9_raw_stall", stall, 1'b1);
        @(negedge clk);
        retireValid = 1'b1; retireDestReg = 5'd9;
        #1;
        $display("step retire_x9: stall=%b", stall);
        check("x9_retire_cycle_stall", stall, 1'b1);
        @(negedge clk);
        retireValid = 1'b0;
        #1;
        $display("step after_retire_x9: busy=%h stall=%b", busyVector, stall);
        check("x9_cleared", busyVector, 32'h0);
        check("x9_stall_clear", stall, 1'b0);

        // WAW on x3
        @(negedge clk);
        idle();
        issueValid = 1'b1; issueLongLat = 1'b1; issueDestReg = 5'd3;
        @(negedge clk);
        #1;
        check("x3_busy", busyVector, 32'h0000_0008);
        retireValid = 1'b1; retireDestReg = 5'd3;
        #1;
        $display("step waw_x3: busy=%h stall=%b", busyVector, stall);
        check("x3_waw_stall", stall, 1'b1);
        @(negedge clk);
        idle();
        #1;
        $display("step after_waw: busy=%h", busyVector);
        check("x3_no_set", busyVector, 32'h0);
        issueValid = 1'b1; issueLongLat = 1'b1; issueDestReg = 5'd3;
        retireValid = 1'b1; retireDestReg = 5'd4;
        #1;
        check("x3_reissue_stall", stall, 1'b0);
        @(negedge clk);
        // Set and clear of x6 together: set wins; retire of idle x10 ignored
        issueDestReg = 5'd6; retireDestReg = 5'd6;
        #1;
        $display("step reissue_x3: busy=%h", busyVector);
        check("x3_set", busyVector, 32'h0000_0008);
        @(negedge clk);
        retireDestReg = 5'd10; issueValid = 1'b0;
        #1;
        $display("step set_wins_x6: busy=%h", busyVector);
        check("x6_set_wins", busyVector, 32'h0000_0048);
        @(negedge clk);
        #1;
        check("x10_ignored", busyVector, 32'h0000_0048);

        // Flush masks stalls and blocks sets, keeps busy bits
        idle();
        flush = 1'b1;
        issueValid = 1'b1; issueLongLat = 1'b1; issueDestReg = 5'd3;
        readValid = 2'b10; readReg = {5'd6, 5'd0};
        #1;
        $display("step flush: stall=%b", stall);
        check("flush_stall", stall, 1'b0);
        @(negedge clk);
        issueDestReg = 5'd12;
        @(negedge clk);
        idle();
        #1;
        $display("step after_flush: busy=%h", busyVector);
        check("flush_keep", busyVector, 32'h0000_0048);

        // x0 never forwarded, never busy
        stageValid = 2'b11; stageWriteEnable = 2'b11; stageDestReg = {5'd0, 5'd0};
        stageDataReady = 2'b11; stageData = {32'h55, 32'h66};
        readValid = 2'b11; readReg = {5'd0, 5'd0};
        issueValid = 1'b1; issueLongLat = 1'b1; issueDestReg = 5'd0;
        #1;
        $display("step x0: fe=%b fd=%h stall=%b", forwardEnable, forwardData, stall);
        check("x0_fe", forwardEnable, 2'b00);
        check("x0_fd", forwardData, 64'h0);
        check("x0_stall", stall, 1'b0);
        @(negedge clk);
        idle();
        #1;
        check("x0_busy", busyVector, 32'h0000_0048);

        // Fill every register, then asynchronous reset mid-cycle
        for (int r = 1; r < NREG; r++) begin
            if (r != 3 && r != 6) begin
                issueValid = 1'b1; issueLongLat = 1'b1; issueDestReg = RW'(r);
                @(negedge clk);
            end
        end
        idle();
        readValid = 2'b01; readReg = {5'd0, 5'd1};
        #1;
        $display("step full: busy=%h stall=%b", busyVector, stall);
        check("full_busy", busyVector, 32'hFFFF_FFFE);
        check("full_stall", stall, 1'b1);
        #1;
        rstN = 1'b0;
        #1;
        $display("step async_reset: busy=%h stall=%b", busyVector, stall);
        check("areset_busy", busyVector, 32'h0);
        check("areset_stall", stall, 1'b0);
`ifdef FWD_PERF_CNT_EN
        check("areset_stallCycles", stallCycles, 32'h0);
        check("areset_forwardHits", forwardHits, 32'h0);
`endif
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/forward_scoreboard.md
Name: forward_scoreboard

Overview:
- Parametrised successor to the pipeline forwarding unit; sits between decode/execute and the later pipeline stages.
- Forwards operands for NUM_READ source ports from NUM_STAGES bypass stages, with a configurable number of both.
- Adds a per-register busy scoreboard for long-latency writers (loads, multi-cycle ops) and generates the pipeline stall that the earlier single-cycle unit left to external logic.

Parameters:
- XLEN, 32, datapath width.
- NUM_READ, 2, number of source-operand ports.
- NUM_STAGES, 2, number of bypass stages; index 0 is the youngest (execute/memory), the highest index is the oldest.
- NUM_REGS, 32, architectural register count; register index width RW = $clog2(NUM_REGS).

Ports:
- clk  in  1  clock.
- rstN  in  1  asynchronous active-low reset.
- readValid  in  NUM_READ  source port p is in use.
- readReg  in  NUM_READ*RW  source register index per port.
- stageValid  in  NUM_STAGES  stage s holds a valid instruction.
- stageWriteEnable  in  NUM_STAGES  stage s writes a GPR.
- stageDestReg  in  NUM_STAGES*RW  destination register of stage s.
- stageDataReady  in  NUM_STAGES  the result of stage s is available this cycle.
- stageData  in  NUM_STAGES*XLEN  result value of stage s.
- issueValid  in  1  an instruction leaves decode this cycle, before stall gating.
- issueLongLat  in  1  the issuing instruction has a long-latency writer.
- issueDestReg  in  RW  destination register of the issuing instruction.
- retireValid  in  1  a long-latency result is written to the register file this cycle.
- retireDestReg  in  RW  destination register of the retiring result.
- flush  in  1  squash the instruction in decode.
- forwardEnable  out  NUM_READ  port p takes bypassed data.
- forwardData  out  NUM_READ*XLEN  bypass value for port p; 0 when forwardEnable[p] is low.
- stall  out  1  hold decode and insert a bubble.
- busyVector  out  NUM_REGS  scoreboard state, registered.

Behaviour:
- Reset (rstN low, asynchronous): busyVector = 0. All outputs are then pure functions of the inputs. With no valid stage, forwardEnable = 0, forwardData = 0 and stall = 0.
- Per port p, combinational and zero latency:
  - If readValid[p] = 0 or readReg[p] = 0, then forwardEnable[p] = 0 and the port needs no stall.
  - Otherwise take the lowest-index stage s with stageValid & stageWriteEnable & stageDestReg = readReg[p] & stageDestReg != 0.
  - If s is found and stageDataReady[s] = 1: forwardEnable[p] = 1, forwardData[p] = stageData[s].
  - If s is found and stageDataReady[s] = 0: port needs a stall. Older stages are never consulted; youngest match is authoritative.
  - If no stage matches and busyVector[readReg[p]] = 1: port needs a stall (RAW on an in-flight long-latency write).
- WAW stall: issueValid & issueLongLat & issueDestReg != 0 & busyVector[issueDestReg] = 1 requires a stall, so at most one outstanding long-latency writer exists per register.
- stall = OR of all port stall needs OR the WAW stall. stall is forced to 0 when flush = 1.
- Scoreboard set, at the clock edge: when issueValid & issueLongLat & issueDestReg != 0 & !stall & !flush, set busyVector[issueDestReg].
- Scoreboard clear, at the clock edge: when retireValid & retireDestReg != 0, clear busyVector[retireDestReg].
- Set and clear on the same register in the same cycle: set wins; the new writer is younger.
- Register 0 is never set busy and never forwarded.
- flush does not clear busy bits; in-flight writers past decode still retire.
- retireValid on a non-busy register is ignored; the bit stays 0.

Optional Feature:
- Macro: FWD_PERF_CNT_EN.
- Defined: adds two outputs, stallCycles (32) and forwardHits (32), both reset to 0 and both saturating at all-ones.
  - stallCycles increments every cycle stall = 1.
  - forwardHits adds popcount(forwardEnable) each cycle stall = 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- NUM_READ=2, NUM_STAGES=2. Stage0 writes x5 = 0x11, stage1 writes x5 = 0x22, both ready; readReg = {5,5} -> forwardEnable = 2'b11, both forwardData = 0x11, stall = 0.
- Stage0 writes x7 with stageDataReady = 0, stage1 writes x7 = 0x33 ready; port0 reads x7 -> stall = 1, forwardEnable[0] = 0; next cycle stage0 ready with 0x44 -> forwardData[0] = 0x44, stall = 0.
- Issue long-latency load to x9 (not stalled) -> busyVector[9] = 1 the next cycle. A read of x9 with no stage match gives stall = 1 until retireValid with x9, then busyVector[9] = 0 and stall = 0 the same cycle the bit clears.
- busyVector[3] = 1; same cycle issue long-latency to x3 and retire x3 -> WAW stall = 1 and no set. Repeat with busyVector[3] = 0: issue and unrelated retire -> busyVector[3] = 1.
- Read x0 while every stage targets x0 -> forwardEnable = 0, stall = 0. Issue long-latency to x0 -> busyVector stays 0.
- Assert rstN low mid-run with busyVector = 0xFFFF_FFFE -> busyVector = 0 immediately (asynchronous), stall = 0. With FWD_PERF_CNT_EN defined, stallCycles = 0 and forwardHits = 0.
